uart_cmd_frame_parser: RTL and testbench

- Receive-side counterpart to the UART telemetry frame formatter: consumes bytes from the UART receiver and parses host command frames of the form "(TTTT)(DDD)".
- TTTT is a 4-byte ASCII command tag. DDD is exactly 3 ASCII decimal digits.
- Outputs the tag packed into 32 bits, the value converted to binary, and a one-cycle valid strobe. Malformed or stalled frames produce an error strobe with a code.
- Sits between the UART RX byte deframer and the robot command dispatcher.

---
 rtl/uart_cmd_frame_parser.sv | 211 +++++++++++++++++++++
 tb/tb_uart_cmd_frame_parser.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_frame_parser.sv
// uart_cmd_frame_parser
//   Parses host command frames of the form "(TTTT)(DDD)" from a UART RX byte
//   stream. TTTT is a 4-byte printable ASCII tag and DDD is exactly three
//   decimal digits. A good frame updates cmd_tag/cmd_value and pulses
//   cmd_valid. A malformed or stalled frame pulses frame_err and latches
//   err_code.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   rx_data    received byte, qualified by rx_valid
//   rx_valid   one-cycle strobe per byte; may be high on consecutive cycles
//   cmd_tag    last good tag; first byte in [31:24], fourth byte in [7:0]
//   cmd_value  last good value in binary (0..999)
//   cmd_valid  one-cycle pulse when cmd_tag/cmd_value update
//   frame_err  one-cycle pulse when a frame is aborted
//   err_code   cause of the last abort (1 bad byte, 2 timeout, 3 resync)
module uart_cmd_frame_parser #(
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] cmd_tag,
  output logic [9:0]  cmd_value,
  output logic        cmd_valid,
  output logic        frame_err,
  output logic [1:0]  err_code
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_TAG       = 3'd1;
  localparam logic [2:0] S_TAG_CLOSE = 3'd2;
  localparam logic [2:0] S_VAL_OPEN  = 3'd3;
  localparam logic [2:0] S_VAL       = 3'd4;
  localparam logic [2:0] S_VAL_CLOSE = 3'd5;

  localparam logic [7:0] CH_LP = 8'h28;  // '('
  localparam logic [7:0] CH_RP = 8'h29;  // ')'

  localparam logic [1:0] ERR_BAD     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_RESYNC  = 2'd3;

  // The counter only has to reach TIMEOUT_CYCLES-1, so clog2 bits suffice.
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state_q,     state_d;
  logic [1:0]       idx_q,       idx_d;
  logic [31:0]      tag_sr_q,    tag_sr_d;
  logic [9:0]       acc_q,       acc_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [31:0]      cmd_tag_q,   cmd_tag_d;
  logic [9:0]       cmd_value_q, cmd_value_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             frame_err_q, frame_err_d;
  logic [1:0]       err_code_q,  err_code_d;

  // Byte classification
  logic is_lp, is_rp, is_digit, is_tag_char;
  logic [3:0]  digit;
  logic [13:0] acc_next;

  always_comb begin
    is_lp       = (rx_data == CH_LP);
    is_rp       = (rx_data == CH_RP);
    is_digit    = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_tag_char = (rx_data >= 8'h20) && (rx_data <= 8'h7E) && !is_lp && !is_rp;
    digit       = rx_data[3:0];
    // Three digits top out at 999, so the truncation back to 10 bits is lossless.
    acc_next    = ({4'd0, acc_q} * 14'd10) + {10'd0, digit};
  end

  logic bad_byte;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tag_sr_d    = tag_sr_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    cmd_tag_d   = cmd_tag_q;
    cmd_value_d = cmd_value_q;
    cmd_valid_d = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    bad_byte    = 1'b0;

    if (rx_valid) begin
      // A byte arriving on the threshold cycle wins over the timeout.
      cnt_d = '0;
      case (state_q)
        S_IDLE: begin
          // Line noise between frames is silently dropped.
          if (is_lp) begin
            state_d = S_TAG;
            idx_d   = 2'd0;
          end
        end
        S_TAG: begin
          if (is_tag_char) begin
            tag_sr_d = {tag_sr_q[23:0], rx_data};
            if (idx_q == 2'd3) begin
              state_d = S_TAG_CLOSE;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end else begin
            bad_byte = 1'b1;
          end
        end
        S_TAG_CLOSE: begin
          if (is_rp) state_d = S_VAL_OPEN;
          else       bad_byte = 1'b1;
        end
        S_VAL_OPEN: begin
          if (is_lp) begin
            state_d = S_VAL;
            acc_d   = '0;
            idx_d   = 2'd0;
          end else begin
            bad_byte = 1'b1;
          end
        end
        S_VAL: begin
          if (is_digit) begin
            acc_d = acc_next[9:0];
            if (idx_q == 2'd2) begin
              state_d = S_VAL_CLOSE;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end else begin
            bad_byte = 1'b1;
          end
        end
        S_VAL_CLOSE: begin
          if (is_rp) begin
            state_d     = S_IDLE;
            cmd_tag_d   = tag_sr_q;
            cmd_value_d = acc_q;
            cmd_valid_d = 1'b1;
          end else begin
            bad_byte = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // An out-of-place '(' is taken as the host restarting a frame, so the
      // parser resyncs straight into the tag instead of dropping to IDLE.
      if (bad_byte) begin
        frame_err_d = 1'b1;
        if (is_lp) begin
          err_code_d = ERR_RESYNC;
          state_d    = S_TAG;
          idx_d      = 2'd0;
        end else begin
          err_code_d = ERR_BAD;
          state_d    = S_IDLE;
        end
      end
    end else if (state_q != S_IDLE) begin
      if (cnt_q == CNT_MAX) begin
        frame_err_d = 1'b1;
        err_code_d  = ERR_TIMEOUT;
        state_d     = S_IDLE;
        cnt_d       = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      tag_sr_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      cmd_tag_q   <= '0;
      cmd_value_q <= '0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tag_sr_q    <= tag_sr_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      cmd_tag_q   <= cmd_tag_d;
      cmd_value_q <= cmd_value_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign cmd_tag   = cmd_tag_q;
  assign cmd_value = cmd_value_q;
  assign cmd_valid = cmd_valid_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_cmd_frame_parser.sv
module tb_uart_cmd_frame_parser;
  localparam int T = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [31:0] cmd_tag;
  logic [9:0]  cmd_value;
  logic        cmd_valid;
  logic        frame_err;
  logic [1:0]  err_code;

  uart_cmd_frame_parser #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_tag(cmd_tag), .cmd_value(cmd_value), .cmd_valid(cmd_valid),
    .frame_err(frame_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_valid = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: the bytes of the current frame are kept in a queue and
  // each new byte is judged by its position in "(TTTT)(DDD)".
  logic [7:0]  fb[$];
  int          gap;
  logic [31:0] m_tag;
  logic [9:0]  m_val;
  logic        m_valid, m_err;
  logic [1:0]  m_code;

  function automatic bit accept(input int p, input logic [7:0] b);
    case (p)
      1, 2, 3, 4: return (b >= 8'h20) && (b <= 8'h7E) && (b != 8'h28) && (b != 8'h29);
      5, 10:      return b == 8'h29;
      6:          return b == 8'h28;
      7, 8, 9:    return (b >= 8'h30) && (b <= 8'h39);
      default:    return 1'b0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb.delete(); gap = 0;
      m_tag = '0; m_val = '0; m_valid = 0; m_err = 0; m_code = '0;
    end else begin
      m_valid = 0; m_err = 0;
      if (rx_valid) begin
        gap = 0;
        if (fb.size() == 0) begin
          if (rx_data == 8'h28) fb.push_back(rx_data);
        end else if (accept(fb.size(), rx_data)) begin
          fb.push_back(rx_data);
          if (fb.size() == 11) begin
            m_tag   = {fb[1], fb[2], fb[3], fb[4]};
            m_val   = 10'((int'(fb[7]) - 48) * 100 + (int'(fb[8]) - 48) * 10 + (int'(fb[9]) - 48));
            m_valid = 1;
            fb.delete();
          end
        end else if (rx_data == 8'h28) begin
          m_err = 1; m_code = 2'd3;
          fb.delete(); fb.push_back(rx_data);
        end else begin
          m_err = 1; m_code = 2'd1;
          fb.delete();
        end
      end else if (fb.size() != 0) begin
        gap++;
        if (gap == T) begin
          m_err = 1; m_code = 2'd2;
          fb.delete(); gap = 0;
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("cmd_valid", {31'd0, cmd_valid}, {31'd0, m_valid});
    check("frame_err", {31'd0, frame_err}, {31'd0, m_err});
    check("err_code",  {30'd0, err_code},  {30'd0, m_code});
    check("cmd_tag",   cmd_tag,            m_tag);
    check("cmd_value", {22'd0, cmd_value}, {22'd0, m_val});
    check("excl",      {31'd0, cmd_valid & frame_err}, 32'd0);
    if (cmd_valid) n_valid++;
    if (frame_err) n_err++;
  end

  task automatic send_str(input string s, input int gap_cyc);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = s[i];
      if (gap_cyc > 0) begin
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap_cyc - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1;
    check("rst_tag",   cmd_tag, 32'd0);
    check("rst_value", {22'd0, cmd_value}, 32'd0);
    check("rst_flags", {29'd0, cmd_valid, frame_err, err_code}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // 1: spaced good frame
    n_valid = 0; n_err = 0;
    send_str("(MOVE)(123)", 10);
    idle(3);
    check("t1_nvalid", n_valid, 1);
    check("t1_nerr",   n_err, 0);
    check("t1_tag",    cmd_tag, 32'h4D4F5645);
    check("t1_value",  {22'd0, cmd_value}, 32'd123);

    // 2: bad digit then recovery
    n_valid = 0; n_err = 0;
    send_str("(STOP)(1A3)", 0);
    idle(3);
    check("t2_nerr",   n_err, 1);
    check("t2_nvalid", n_valid, 0);
    check("t2_code",   {30'd0, err_code}, 32'd1);
    check("t2_tag",    cmd_tag, 32'h4D4F5645);
    send_str("(TURN)(045)", 2);
    idle(3);
    check("t2_tag2",   cmd_tag, 32'h5455524E);
    check("t2_value2", {22'd0, cmd_value}, 32'd45);

    // 3: timeout mid-tag
    n_valid = 0; n_err = 0;
    send_str("(MO", 0);
    idle(T + 5);
    check("t3_nerr", n_err, 1);
    check("t3_code", {30'd0, err_code}, 32'd2);
    check("t3_tag",  cmd_tag, 32'h5455524E);

    // 4: resync on '('
    n_valid = 0; n_err = 0;
    send_str("(MO(MOVE)(007)", 1);
    idle(3);
    check("t4_nerr",   n_err, 1);
    check("t4_code",   {30'd0, err_code}, 32'd3);
    check("t4_nvalid", n_valid, 1);
    check("t4_tag",    cmd_tag, 32'h4D4F5645);
    check("t4_value",  {22'd0, cmd_value}, 32'd7);

    // 5: back-to-back with leading noise
    n_valid = 0; n_err = 0;
    send_str("xx(GO!!)(999)(LEFT)(000)", 0);
    idle(3);
    check("t5_nvalid", n_valid, 2);
    check("t5_nerr",   n_err, 0);
    check("t5_tag",    cmd_tag, 32'h4C454654);
    check("t5_value",  {22'd0, cmd_value}, 32'd0);

    // 6: reset mid-frame
    send_str("(MOVE)(12", 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_tag",   cmd_tag, 32'd0);
    check("t6_value", {22'd0, cmd_value}, 32'd0);
    check("t6_flags", {29'd0, cmd_valid, frame_err, err_code}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    n_valid = 0; n_err = 0;
    send_str("(BACK)(500)", 0);
    idle(3);
    check("t6_nvalid", n_valid, 1);
    check("t6_tag2",   cmd_tag, 32'h4241434B);
    check("t6_value2", {22'd0, cmd_value}, 32'd500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
